// File: rtl/sram_responder_if.sv
// Pin bundle for the SRAM responder: initiator-driven strobes/address
// plus the responder's status outputs. The data bus stays a module inout.
interface sram_responder_if;
    logic [19:0] sram_addr;
    logic        sram_wr_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        busy;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    modport master (
        output sram_addr, sram_wr_n, sram_ce_n, sram_oe_n,
        output sram_ub_n, sram_lb_n,
        input  busy, wr_count, rd_count
    );

    modport slave (
        input  sram_addr, sram_wr_n, sram_ce_n, sram_oe_n,
        input  sram_ub_n, sram_lb_n,
        output busy, wr_count, rd_count
    );
endinterface

// File: rtl/sram_responder.sv
// Async-SRAM pin responder backed by a 2^MEM_AW x 16 array.
// Define SRAM_RESP_BYTE_LANE_EN to honour ub_n/lb_n on write commit and read drive.
module sram_responder #(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 2
) (
    input  logic            clk_50,
    input  logic            rst,
    inout  wire  [15:0]     sram_data,
    sram_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR_ACT, RD_WAIT, RD_DRV} state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t      state;
    state_t      state_n;
    logic [19:0] s_addr;
    logic [15:0] s_data;
    logic        s_wr_n;
    logic        s_ce_n;
    logic        s_oe_n;
    logic [19:0] addr_q;
    logic [19:0] addr_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic [15:0] hold;
    logic [15:0] hold_n;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic        busy_q;
    logic        commit;
    logic        rd_inc;
    logic        rd_stop;
    logic        drive;
    logic        drv_hi;
    logic        drv_lo;
    logic [15:0] rd_word;

    logic [15:0] mem [0:(1<<MEM_AW)-1];

`ifdef SRAM_RESP_BYTE_LANE_EN
    logic s_ub_n;
    logic s_lb_n;
    logic hold_ub_n;
    logic hold_lb_n;
    logic hold_ub_n_n;
    logic hold_lb_n_n;
`else
    logic unused_be;
    assign unused_be = bus.sram_ub_n ^ bus.sram_lb_n;
`endif

    // Strobes clear to their inactive level so reset never fakes an access.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            s_addr <= '0;
            s_data <= '0;
            s_wr_n <= 1'b1;
            s_ce_n <= 1'b1;
            s_oe_n <= 1'b1;
        end else begin
            s_addr <= bus.sram_addr;
            s_data <= sram_data;
            s_wr_n <= bus.sram_wr_n;
            s_ce_n <= bus.sram_ce_n;
            s_oe_n <= bus.sram_oe_n;
        end
    end

`ifdef SRAM_RESP_BYTE_LANE_EN
    always_ff @(posedge clk_50) begin
        if (rst) begin
            s_ub_n    <= 1'b1;
            s_lb_n    <= 1'b1;
            hold_ub_n <= 1'b1;
            hold_lb_n <= 1'b1;
        end else begin
            s_ub_n    <= bus.sram_ub_n;
            s_lb_n    <= bus.sram_lb_n;
            hold_ub_n <= hold_ub_n_n;
            hold_lb_n <= hold_lb_n_n;
        end
    end
`endif

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        cnt_n   = cnt;
        hold_n  = hold;
        commit  = 1'b0;
        rd_inc  = 1'b0;
        rd_stop = s_ce_n | s_oe_n | ~s_wr_n;
`ifdef SRAM_RESP_BYTE_LANE_EN
        hold_ub_n_n = hold_ub_n;
        hold_lb_n_n = hold_lb_n;
`endif
        unique case (state)
            IDLE: begin
                if (!s_ce_n && !s_wr_n) begin
                    state_n = WR_ACT;
                    addr_n  = s_addr;
                    hold_n  = s_data;
`ifdef SRAM_RESP_BYTE_LANE_EN
                    hold_ub_n_n = s_ub_n;
                    hold_lb_n_n = s_lb_n;
`endif
                end else if (!s_ce_n && !s_oe_n) begin
                    state_n = RD_WAIT;
                    addr_n  = s_addr;
                    cnt_n   = LAT;
                end
            end
            WR_ACT: begin
                if (s_wr_n || s_ce_n) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end else begin
                    hold_n = s_data;
`ifdef SRAM_RESP_BYTE_LANE_EN
                    hold_ub_n_n = s_ub_n;
                    hold_lb_n_n = s_lb_n;
`endif
                end
            end
            RD_WAIT: begin
                if (rd_stop) begin
                    state_n = IDLE;
                end else if (cnt == 4'd1) begin
                    state_n = RD_DRV;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RD_DRV: begin
                if (rd_stop) begin
                    rd_inc  = 1'b1;
                    state_n = IDLE;
                end else if (s_addr != addr_q) begin
                    rd_inc  = 1'b1;
                    addr_n  = s_addr;
                    cnt_n   = LAT;
                    state_n = RD_WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            cnt    <= '0;
            hold   <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            hold   <= hold_n;
            wr_cnt <= wr_cnt + {15'd0, commit};
            rd_cnt <= rd_cnt + {15'd0, rd_inc};
            busy_q <= (state_n != IDLE);
        end
    end

    // Array is never reset; a commit racing a reset is dropped.
    always_ff @(posedge clk_50) begin
        if (commit && !rst) begin
`ifdef SRAM_RESP_BYTE_LANE_EN
            if (!hold_ub_n) mem[addr_q[MEM_AW-1:0]][15:8] <= hold[15:8];
            if (!hold_lb_n) mem[addr_q[MEM_AW-1:0]][7:0]  <= hold[7:0];
`else
            mem[addr_q[MEM_AW-1:0]] <= hold;
`endif
        end
    end

    assign rd_word = mem[addr_q[MEM_AW-1:0]];

    // Raw pins gate the driver so a falling wr_n frees the bus immediately.
    assign drive = (state == RD_DRV) && !bus.sram_ce_n
                && !bus.sram_oe_n && bus.sram_wr_n;

`ifdef SRAM_RESP_BYTE_LANE_EN
    assign drv_hi = drive && !bus.sram_ub_n;
    assign drv_lo = drive && !bus.sram_lb_n;
`else
    assign drv_hi = drive;
    assign drv_lo = drive;
`endif

    assign sram_data[15:8] = drv_hi ? rd_word[15:8] : 8'bz;
    assign sram_data[7:0]  = drv_lo ? rd_word[7:0]  : 8'bz;

    assign bus.busy     = busy_q;
    assign bus.wr_count = wr_cnt;
    assign bus.rd_count = rd_cnt;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table of write/read pairs
// plus hand-written contention, abort, reset and wrap sequences.
module tb_sram_responder;
    localparam int RD_LAT = 2;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dat = '0;
    wire  [15:0] sram_data;

    int tests = 0;
    int fails = 0;
    logic [15:0] wexp = '0;
    logic [15:0] rexp = '0;

    sram_responder_if bus();

    sram_responder #(.MEM_AW(10), .RD_LAT(RD_LAT)) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .sram_data (sram_data),
        .bus       (bus.slave)
    );

    assign sram_data = tb_oe ? tb_dat : 16'hzzzz;

    always #10 clk_50 = ~clk_50;

    typedef struct {
        logic [19:0] waddr;
        logic [15:0] wdata;
        logic        ub_n;
        logic        lb_n;
        logic [19:0] raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pins_idle;
        bus.sram_ce_n = 1'b1;
        bus.sram_wr_n = 1'b1;
        bus.sram_oe_n = 1'b1;
        bus.sram_ub_n = 1'b0;
        bus.sram_lb_n = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input int n);
        bus.sram_addr = a;
        bus.sram_ub_n = ub;
        bus.sram_lb_n = lb;
        tb_dat = d;
        tb_oe = 1'b1;
        bus.sram_ce_n = 1'b0;
        bus.sram_wr_n = 1'b0;
        tick(n);
        pins_idle();
        tick(3);
    endtask

    // Leaves the read asserted; bus must show data exactly RD_LAT+2 cycles in.
    task automatic do_read(input logic [19:0] a, input logic [15:0] exp,
                           input string name);
        bus.sram_addr = a;
        bus.sram_wr_n = 1'b1;
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        tick(RD_LAT + 1);
        tests++;
        if (sram_data === exp) begin
            fails++;
            $display("FAIL %s_early: got %h one cycle before allowed", name, sram_data);
        end
        tick(1);
        check(name, sram_data, exp);
        check({name, "_busy"}, {15'd0, bus.busy}, 16'd1);
    endtask

    task automatic end_read;
        pins_idle();
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{20'h00001, 16'hBEEF, 1'b0, 1'b0, 20'h00001, 16'hBEEF};
        vecs[1] = '{20'h00400, 16'hC0DE, 1'b0, 1'b0, 20'h00000, 16'hC0DE};
        vecs[2] = '{20'h003FF, 16'h0001, 1'b0, 1'b0, 20'hFFBFF, 16'h0001};
        vecs[3] = '{20'h00003, 16'hFFFF, 1'b0, 1'b0, 20'h00003, 16'hFFFF};
`ifdef SRAM_RESP_BYTE_LANE_EN
        vecs[4] = '{20'h00003, 16'h1234, 1'b1, 1'b0, 20'h00003, 16'hFF34};
        vecs[5] = '{20'h00003, 16'hABCD, 1'b0, 1'b1, 20'h00003, 16'hAB34};
`else
        vecs[4] = '{20'h00003, 16'h1234, 1'b1, 1'b0, 20'h00003, 16'h1234};
        vecs[5] = '{20'h00003, 16'hABCD, 1'b0, 1'b1, 20'h00003, 16'hABCD};
`endif
        bus.sram_addr = '0;
        pins_idle();
        tick(3);
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_wr_count", bus.wr_count, 16'd0);
        check("rst_rd_count", bus.rd_count, 16'd0);
        rst = 1'b0;
        tick(1);

        do_write(20'h00012, 16'hA5C3, 1'b0, 1'b0, 8);
        wexp++;
        check("full_wr_count", bus.wr_count, wexp);
        do_read(20'h00012, 16'hA5C3, "full_rd");
        end_read();
        rexp++;
        check("full_rd_count", bus.rd_count, rexp);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].ub_n, vecs[i].lb_n, 2);
            wexp++;
            check($sformatf("vec%0d_wr_count", i), bus.wr_count, wexp);
            do_read(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d_rd", i));
            end_read();
            rexp++;
            check($sformatf("vec%0d_rd_count", i), bus.rd_count, rexp);
        end

        // Contention: ce_n/oe_n stay low while wr_n pulses.
        do_read(20'h00012, 16'hA5C3, "cont_pre");
        tb_dat = 16'h5A3C;
        tb_oe = 1'b1;
        bus.sram_wr_n = 1'b0;
        #1;
        check("cont_release", sram_data, 16'h5A3C);
        tick(4);
        check("cont_strobe", sram_data, 16'h5A3C);
        bus.sram_wr_n = 1'b1;
        tb_oe = 1'b0;
        tick(6);
        check("cont_readback", sram_data, 16'h5A3C);
        wexp++;
        rexp++;
        check("cont_wr_count", bus.wr_count, wexp);
        end_read();
        rexp++;
        check("cont_rd_count", bus.rd_count, rexp);

        // Abort from RD_WAIT.
        bus.sram_addr = 20'h00001;
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        tick(2);
        check("abort_busy_wait", {15'd0, bus.busy}, 16'd1);
        bus.sram_oe_n = 1'b1;
        bus.sram_ce_n = 1'b1;
        tick(3);
        check("abort_busy_idle", {15'd0, bus.busy}, 16'd0);
        check("abort_rd_count", bus.rd_count, rexp);

        // Reset mid-WR_ACT discards the write.
        bus.sram_addr = 20'h00012;
        tb_dat = 16'hDEAD;
        tb_oe = 1'b1;
        bus.sram_ce_n = 1'b0;
        bus.sram_wr_n = 1'b0;
        tick(4);
        check("rstwr_busy_pre", {15'd0, bus.busy}, 16'd1);
        rst = 1'b1;
        pins_idle();
        tick(1);
        check("rstwr_busy", {15'd0, bus.busy}, 16'd0);
        check("rstwr_wr_count", bus.wr_count, 16'd0);
        check("rstwr_rd_count", bus.rd_count, 16'd0);
        rst = 1'b0;
        wexp = '0;
        rexp = '0;
        tick(2);
        do_read(20'h00012, 16'h5A3C, "rstwr_mem");
        end_read();
        rexp++;

        // Reset while driving: bus must be free right after the edge.
        do_read(20'h00001, 16'hBEEF, "rstrd_pre");
        rst = 1'b1;
        tick(1);
        tb_dat = 16'h0000;
        tb_oe = 1'b1;
        #1;
        check("rstrd_release", sram_data, 16'h0000);
        pins_idle();
        rst = 1'b0;
        wexp = '0;
        rexp = '0;
        tick(2);

        // Wrap: preset the counter instead of 65535 real writes.
        force dut.wr_cnt = 16'hFFFF;
        #1;
        release dut.wr_cnt;
        do_write(20'h00005, 16'h0F0F, 1'b0, 1'b0, 1);
        check("wrap_wr_count", bus.wr_count, 16'h0000);
        do_read(20'h00005, 16'h0F0F, "wrap_rd");
        end_read();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
